instr_fetch_ctrl: RTL and testbench

Fetch/next-PC controller at the consuming end of the PC register in the non-pipelined MIPS core.
- Reads currentPointer from the PC and fetches the instruction over a req/ack instruction-memory handshake.
- Holds the instruction until execute signals completion, then computes the next address.
- Drives memLoc/outputEnable back into the PC. Also loads the reset vector into the PC, since the PC register has no reset.

---
 rtl/instr_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Fetch/next-PC controller: loads the reset vector into the PC, fetches over imem req/ack, computes next PC on exec_done.
// Min 3 cycles per instruction; stalls in REQ (timeout fault) and WAIT_EXEC. `define MISALIGN_TRAP_EN for alignment fault.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] currentPointer,
    output logic [31:0] memLoc,
    output logic        outputEnable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic        fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        REQ,
        WAIT_EXEC,
        UPDATE,
        FAULT_ST
    } state_t;

    state_t        state;
    logic [CW-1:0] toCnt;
    logic [31:0]   pc4;
    logic [31:0]   brOff;
    logic [31:0]   nextPc;
    logic          addrMis;
    logic          nextMis;

    assign pc4    = currentPointer + 32'd4;
    assign brOff  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign nextPc = jump         ? {pc4[31:28], jump_target, 2'b00} :
                    branch_taken ? pc4 + brOff : pc4;

`ifdef MISALIGN_TRAP_EN
    assign addrMis = (currentPointer[1:0] != 2'b00);
    assign nextMis = (nextPc[1:0] != 2'b00);
`else
    assign addrMis = 1'b0;
    assign nextMis = 1'b0;
`endif

    // Request is decoded from the state register so an async reset drops it at once.
    assign imem_req  = (state == REQ) && !addrMis;
    assign imem_addr = currentPointer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            memLoc       <= 32'd0;
            outputEnable <= 1'b0;
            instr        <= 32'd0;
            instr_valid  <= 1'b0;
            fault        <= 1'b0;
            toCnt        <= '0;
        end else begin
            outputEnable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        memLoc       <= RESET_VECTOR;
                        outputEnable <= 1'b1;
                        state        <= INIT;
                    end
                end
                INIT: begin
                    toCnt <= '0;
                    state <= REQ;
                end
                REQ: begin
                    if (addrMis) begin
                        fault <= 1'b1;
                        state <= FAULT_ST;
                    end else if (imem_ack) begin
                        // An ack in the last allowed cycle still wins over the timeout.
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        toCnt       <= '0;
                        state       <= WAIT_EXEC;
                    end else if (toCnt == CNT_LAST) begin
                        fault <= 1'b1;
                        state <= FAULT_ST;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                WAIT_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        if (nextMis) begin
                            fault <= 1'b1;
                            state <= FAULT_ST;
                        end else begin
                            memLoc       <= nextPc;
                            outputEnable <= 1'b1;
                            state        <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    state <= REQ;
                end
                FAULT_ST: begin
                    state <= FAULT_ST;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboarded bench for instr_fetch_ctrl with a behavioural PC register feeding currentPointer.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] currentPointer;
    logic [31:0] memLoc;
    logic        outputEnable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'd0;
    logic        fault;

    logic [31:0] pcReg = 32'd0;
    logic        usePcOvr = 1'b0;
    logic [31:0] pcOvr = 32'd0;

    int nTests = 0;
    int nFails = 0;

    logic [31:0] memLocQ[$];
    logic [31:0] addrQ[$];
    logic [31:0] instrQ[$];
    logic        prevValid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) if (outputEnable) pcReg <= memLoc;
    assign currentPointer = usePcOvr ? pcOvr : pcReg;

    instr_fetch_ctrl #(
        .RESET_VECTOR  (32'h0040_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .currentPointer(currentPointer),
        .memLoc        (memLoc),
        .outputEnable  (outputEnable),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .fault         (fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        nTests++;
        nFails++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a PC load, a handshake or a new instruction.
    always @(negedge clk) begin
        if (reset) begin
            prevValid <= 1'b0;
        end else begin
            if (outputEnable) begin
                if (memLocQ.size() == 0) unexpected("memLoc pulse", memLoc);
                else chk("memLoc", memLoc, memLocQ.pop_front());
            end
            if (imem_req && imem_ack) begin
                if (addrQ.size() == 0) unexpected("imem_addr handshake", imem_addr);
                else chk("imem_addr", imem_addr, addrQ.pop_front());
            end
            if (instr_valid && !prevValid) begin
                if (instrQ.size() == 0) unexpected("instr", instr);
                else chk("instr", instr, instrQ.pop_front());
            end
            prevValid <= instr_valid;
        end
    end

    task automatic waitReq();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait for imem_req", 32'(imem_req), 32'd1);
    endtask

    task automatic doInstr(input logic [31:0] rdata, input logic br, input logic [15:0] off,
                           input logic jmp, input logic [25:0] tgt, input logic ovr,
                           input logic [31:0] ovrPc, input int reqWait, input int stall,
                           input logic [31:0] expAddr, input logic [31:0] expNext);
        waitReq();
        usePcOvr = ovr;
        pcOvr    = ovrPc;
        for (int i = 0; i < reqWait; i++) begin
            exec_done = 1'b1;
            @(posedge clk); #1;
            exec_done = 1'b0;
            chk("REQ held without ack", 32'({fault, imem_req, outputEnable}), 32'b010);
        end
        addrQ.push_back(expAddr);
        instrQ.push_back(rdata);
        memLocQ.push_back(expNext);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = ~rdata;
        chk("WAIT_EXEC strobes", 32'({instr_valid, imem_req}), 32'b10);
        for (int i = 0; i < stall; i++) begin
            imem_ack     = 1'b1;
            branch_taken = 1'b1;
            jump         = 1'b1;
            @(posedge clk); #1;
            imem_ack     = 1'b0;
            branch_taken = 1'b0;
            jump         = 1'b0;
            chk("instr held in WAIT_EXEC", instr, rdata);
        end
        exec_done     = 1'b1;
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_target   = tgt;
        @(posedge clk); #1;
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        usePcOvr     = 1'b0;
        chk("UPDATE strobes", 32'({outputEnable, instr_valid, imem_req}), 32'b100);
        @(posedge clk); #1;
        chk("back in REQ after 3-cycle loop", 32'(imem_req), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset memLoc", memLoc, 32'd0);
        chk("reset instr", instr, 32'd0);
        chk("reset strobes", 32'({outputEnable, imem_req, instr_valid, fault}), 32'd0);
        reset = 1'b0;

        // First fetch timing, then reset in the middle of REQ.
        memLocQ.push_back(32'h0040_0000);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("INIT strobes", 32'({outputEnable, imem_req}), 32'b10);
        @(posedge clk); #1;
        chk("first req 2 cycles after start", 32'(imem_req), 32'd1);
        chk("first imem_addr", imem_addr, 32'h0040_0000);
        #2;
        reset = 1'b1;
        #1;
        chk("imem_req drops on reset", 32'(imem_req), 32'd0);
        chk("strobes in reset", 32'({outputEnable, instr_valid, fault}), 32'd0);
        chk("memLoc in reset", memLoc, 32'd0);
        start      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late ack ignored", 32'({imem_req, instr_valid, fault}), 32'd0);
        chk("instr after late ack", instr, 32'd0);
        imem_ack = 1'b0;

        // Normal run; start dropped mid-run must not stop fetching.
        memLocQ.push_back(32'h0040_0000);
        start = 1'b1;
        @(posedge clk); #1;
        doInstr(32'h2008_0005, 0, 16'h0000, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0040_0000, 32'h0040_0004);
        start = 1'b0;
        doInstr(32'h8C09_0000, 0, 16'h0000, 0, 26'h0, 0, 32'h0, 0, 1, 32'h0040_0004, 32'h0040_0008);
        doInstr(32'h1000_FFFC, 1, 16'hFFFC, 0, 26'h0, 1, 32'h0040_0010, 0, 0, 32'h0040_0010, 32'h0040_0004);
        doInstr(32'h0810_0000, 1, 16'hFFFC, 1, 26'h010_0000, 1, 32'h0040_0010, 0, 0, 32'h0040_0010, 32'h0040_0000);
        doInstr(32'h1000_0003, 1, 16'h0003, 0, 26'h0, 0, 32'h0, 3, 0, 32'h0040_0000, 32'h0040_0010);
        chk("ack in last cycle avoids fault", 32'(fault), 32'd0);
        doInstr(32'h0BFF_FFFF, 0, 16'h0000, 1, 26'h3FF_FFFF, 1, 32'hA000_0000, 0, 0, 32'hA000_0000, 32'hAFFF_FFFC);
        doInstr(32'h0000_0000, 0, 16'h0000, 0, 26'h0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000);
        doInstr(32'h1000_0002, 1, 16'h0002, 0, 26'h0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 32'h0000_0004);

        // Timeout: no ack for 4 REQ cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("timeout pending", 32'({fault, imem_req}), 32'b01);
        end
        @(posedge clk); #1;
        chk("timeout fault", 32'({fault, imem_req}), 32'b10);
        start     = 1'b1;
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("fault sticky", 32'({fault, imem_req, outputEnable, instr_valid}), 32'b1000);
        start     = 1'b0;
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        reset = 1'b1;
        #1;
        chk("fault cleared by reset", 32'(fault), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Misaligned fetch address.
        memLocQ.push_back(32'h0040_0000);
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        usePcOvr = 1'b1;
        pcOvr    = 32'h0000_0002;
        @(posedge clk); #1;
`ifdef MISALIGN_TRAP_EN
        chk("misaligned: no request", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        chk("misaligned: fault", 32'({fault, imem_req}), 32'b10);
        usePcOvr = 1'b0;
`else
        chk("misaligned addr issued", imem_addr, 32'h0000_0002);
        doInstr(32'h2008_0001, 0, 16'h0000, 0, 26'h0, 1, 32'h0000_0002, 0, 0, 32'h0000_0002, 32'h0000_0006);
        chk("no fault without trap", 32'(fault), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("memLoc queue drained", 32'(memLocQ.size()), 32'd0);
        chk("addr queue drained", 32'(addrQ.size()), 32'd0);
        chk("instr queue drained", 32'(instrQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
